// File: rtl/arm_mem_responder.sv
// Memory-side responder for the multicycle ARM core: word RAM plus an I/O page
// holding a cycle counter, a console byte FIFO, a status register and a halt flag.
module arm_mem_responder #(
    parameter int          MEM_WORDS  = 64,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] IO_BASE    = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] Adr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        halted,
    output logic        bus_err
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [9:0] OFF_CYCLE   = 10'd0;
    localparam logic [9:0] OFF_CONSOLE = 10'd1;
    localparam logic [9:0] OFF_STATUS  = 10'd2;
    localparam logic [9:0] OFF_HALT    = 10'd3;

    logic [31:0]   r_mem [MEM_WORDS];
    logic [7:0]    r_fifo [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic          r_halted;
    logic          r_bus_err;
    logic [31:0]   r_cycle;

    logic          w_ram_sel;
    logic          w_io_sel;
    logic [9:0]    w_off;
    logic [AW-1:0] w_ram_idx;
    logic          w_wr_ok;
    logic          w_push;
    logic          w_push_ok;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [3:0]    w_cnt4;
    logic [31:0]   w_rdata;
    logic [1:0]    w_unused_adr_lo;

    assign w_unused_adr_lo = Adr[1:0];

    assign w_ram_sel = (Adr[31:AW+2] == '0);
    assign w_io_sel  = (Adr[31:12] == IO_BASE[31:12]);
    assign w_off     = Adr[11:2];
    assign w_ram_idx = Adr[AW+1:2];

    // Once halted, the core can no longer change any state through the bus.
    assign w_wr_ok   = MemWrite & ~r_halted;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CW'(FIFO_DEPTH));
    assign w_cnt4    = 4'(r_count);
    assign w_pop     = ~w_empty & tx_ready;
    assign w_push    = w_wr_ok & w_io_sel & (w_off == OFF_CONSOLE);
    assign w_push_ok = w_push & (~w_full | w_pop);

    always_comb begin
        w_rdata = '0;
        if (w_ram_sel) begin
            w_rdata = r_mem[w_ram_idx];
        end else if (w_io_sel) begin
            case (w_off)
                OFF_CYCLE:  w_rdata = r_cycle;
                OFF_STATUS: w_rdata = {24'b0, w_cnt4, r_halted, r_ovf, w_full, w_empty};
                OFF_HALT:   w_rdata = {31'b0, r_halted};
                default:    w_rdata = '0;
            endcase
        end
    end

    // RAM writes ignore reset so that a program load overlapping reset still lands.
    always_ff @(posedge clk) begin
        if (w_wr_ok && w_ram_sel) begin
            r_mem[w_ram_idx] <= WriteData;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_push_ok) begin
            r_fifo[r_wr_ptr] <= WriteData[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push_ok && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push_ok && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            if (w_push && !w_push_ok) begin
                r_ovf <= 1'b1;
            end else if (w_wr_ok && w_io_sel && (w_off == OFF_STATUS)) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_halted  <= 1'b0;
            r_bus_err <= 1'b0;
            r_cycle   <= '0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
            if (w_wr_ok && w_io_sel && (w_off == OFF_HALT)) begin
                r_halted <= 1'b1;
            end
            if (w_wr_ok && !w_ram_sel && !w_io_sel) begin
                r_bus_err <= 1'b1;
            end
        end
    end

    assign ReadData = w_rdata;
    assign tx_valid = ~w_empty;
    assign tx_data  = r_fifo[r_rd_ptr];
    assign halted   = r_halted;
    assign bus_err  = r_bus_err;

endmodule
